// File: rtl/escalonador_pkg.sv
// rtl/escalonador_pkg.sv - shared encodings for the round-robin process scheduler
package escalonador_pkg;

    typedef enum logic [1:0] {
        LIVRE  = 2'd0,
        PRONTO = 2'd1,
        EXEC   = 2'd2,
        BLOQ   = 2'd3
    } slot_estado_t;

    typedef enum logic [2:0] {
        FSM_OCIOSO   = 3'd0,
        FSM_RUN      = 3'd1,
        FSM_SAVE     = 3'd2,
        FSM_SELECT   = 3'd3,
        FSM_DISPATCH = 3'd4
    } fsm_estado_t;

    typedef enum logic [1:0] {
        CAUSA_FIM     = 2'd0,
        CAUSA_IO      = 2'd1,
        CAUSA_QUANTUM = 2'd2
    } causa_t;

    localparam logic [31:0] PID_OCIOSO = 32'd0;

endpackage

// File: rtl/seletor_round_robin.sv
// rtl/seletor_round_robin.sv - first set bit of a mask, searching circularly from inicio_i
module seletor_round_robin #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  mascara_i,
    input  logic [IW-1:0] inicio_i,
    output logic          encontrado_o,
    output logic [IW-1:0] vencedor_o
);

    // Scanning from the far end lets the candidate closest to inicio_i overwrite the rest.
    always_comb begin
        encontrado_o = 1'b0;
        vencedor_o   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (mascara_i[(int'(inicio_i) + k) % N]) begin
                encontrado_o = 1'b1;
                vencedor_o   = IW'((int'(inicio_i) + k) % N);
            end
        end
    end

endmodule

// File: rtl/escalonador_processos.sv
// rtl/escalonador_processos.sv - round-robin process table, quantum counter and CPU dispatch handshake
module escalonador_processos
    import escalonador_pkg::*;
#(
    parameter int NUM_PROC = 4,
    parameter int QUANTUM  = 16,
    parameter int PC_W     = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            instr_exec,
    input  logic [PC_W-1:0] pc_atual,
    input  logic            fim_proc,
    input  logic            io_bloq,
    input  logic            io_libera,
    input  logic [31:0]     io_pid,
    input  logic            cria_valid,
    input  logic [PC_W-1:0] cria_pc,
    output logic            cria_ready,
    output logic [31:0]     cria_pid,
    output logic            troca_contexto,
    input  logic            troca_ack,
    output logic [PC_W-1:0] pc_proximo,
    output logic [31:0]     processo_atual,
    output logic            ocioso,
    output logic [2:0]      num_ativos
);

    localparam int IW = (NUM_PROC > 1) ? $clog2(NUM_PROC) : 1;
    localparam int CW = $clog2(QUANTUM);
    localparam logic [IW-1:0] ULTIMO = IW'(NUM_PROC - 1);

    slot_estado_t    estado_q [NUM_PROC];
    slot_estado_t    estado_d [NUM_PROC];
    logic [PC_W-1:0] pc_tab_q [NUM_PROC];
    logic [PC_W-1:0] pc_tab_d [NUM_PROC];
    fsm_estado_t     fsm_q, fsm_d;
    causa_t          causa_q, causa_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [IW-1:0]   cur_q, cur_d;
    logic [31:0]     pid_q, pid_d;
    logic [31:0]     cria_pid_q, cria_pid_d;
    logic [PC_W-1:0] pc_prox_q, pc_prox_d;
    logic [PC_W-1:0] pc_lat_q, pc_lat_d;

    logic [NUM_PROC-1:0] mask_pronto, mask_livre;
    logic [IW-1:0]       inicio_sel, sel_idx, livre_idx, io_idx;
    logic                sel_found, livre_found, io_ok, fim_quantum;

    always_comb begin
        mask_pronto = '0;
        mask_livre  = '0;
        num_ativos  = 3'd0;
        for (int k = 0; k < NUM_PROC; k++) begin
            mask_pronto[k] = (estado_q[k] == PRONTO);
            mask_livre[k]  = (estado_q[k] == LIVRE);
            if (estado_q[k] != LIVRE) begin
                num_ativos = num_ativos + 3'd1;
            end
        end
    end

    // Search begins after the current slot so the current one is considered last.
    assign inicio_sel = (cur_q == ULTIMO) ? '0 : cur_q + 1'b1;

    seletor_round_robin #(.N(NUM_PROC), .IW(IW)) u_sel_pronto (
        .mascara_i    (mask_pronto),
        .inicio_i     (inicio_sel),
        .encontrado_o (sel_found),
        .vencedor_o   (sel_idx)
    );

    seletor_round_robin #(.N(NUM_PROC), .IW(IW)) u_sel_livre (
        .mascara_i    (mask_livre),
        .inicio_i     ('0),
        .encontrado_o (livre_found),
        .vencedor_o   (livre_idx)
    );

    assign io_ok       = io_libera && (io_pid >= 32'd1) && (io_pid <= 32'(NUM_PROC));
    assign io_idx      = IW'(io_pid - 32'd1);
    assign fim_quantum = instr_exec && (cnt_q == CW'(QUANTUM - 1));

    always_comb begin
        estado_d   = estado_q;
        pc_tab_d   = pc_tab_q;
        fsm_d      = fsm_q;
        causa_d    = causa_q;
        cnt_d      = cnt_q;
        cur_d      = cur_q;
        pid_d      = pid_q;
        cria_pid_d = cria_pid_q;
        pc_prox_d  = pc_prox_q;
        pc_lat_d   = pc_lat_q;

        case (fsm_q)
            FSM_OCIOSO: begin
                if (|mask_pronto) fsm_d = FSM_SELECT;
            end
            FSM_RUN: begin
                if (fim_proc || io_bloq || fim_quantum) begin
                    causa_d  = fim_proc ? CAUSA_FIM : (io_bloq ? CAUSA_IO : CAUSA_QUANTUM);
                    pc_lat_d = pc_atual;
                    fsm_d    = FSM_SAVE;
                end else if (instr_exec) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            FSM_SAVE: begin
                case (causa_q)
                    CAUSA_FIM: estado_d[cur_q] = LIVRE;
                    CAUSA_IO: begin
                        estado_d[cur_q] = BLOQ;
                        pc_tab_d[cur_q] = pc_lat_q;
                    end
                    default: begin
                        estado_d[cur_q] = PRONTO;
                        pc_tab_d[cur_q] = pc_lat_q;
                    end
                endcase
                fsm_d = FSM_SELECT;
            end
            FSM_SELECT: begin
                if (sel_found) begin
                    pid_d             = 32'(sel_idx) + 32'd1;
                    pc_prox_d         = pc_tab_q[sel_idx];
                    estado_d[sel_idx] = EXEC;
                    cur_d             = sel_idx;
                    fsm_d             = FSM_DISPATCH;
                end else begin
                    pid_d = PID_OCIOSO;
                    fsm_d = FSM_OCIOSO;
                end
            end
            FSM_DISPATCH: begin
                if (troca_ack) begin
                    cnt_d = '0;
                    fsm_d = FSM_RUN;
                end
            end
            default: fsm_d = FSM_OCIOSO;
        endcase

        // Creation only targets LIVRE slots and release only BLOQ ones, so neither
        // can collide with the FSM's write to the EXEC or selected PRONTO slot.
        if (cria_valid && livre_found) begin
            estado_d[livre_idx] = PRONTO;
            pc_tab_d[livre_idx] = cria_pc;
            cria_pid_d          = 32'(livre_idx) + 32'd1;
        end
        if (io_ok && estado_q[io_idx] == BLOQ) begin
            estado_d[io_idx] = PRONTO;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < NUM_PROC; k++) begin
                estado_q[k] <= LIVRE;
                pc_tab_q[k] <= '0;
            end
            fsm_q      <= FSM_OCIOSO;
            causa_q    <= CAUSA_FIM;
            cnt_q      <= '0;
            cur_q      <= ULTIMO;
            pid_q      <= PID_OCIOSO;
            cria_pid_q <= '0;
            pc_prox_q  <= '0;
            pc_lat_q   <= '0;
        end else begin
            estado_q   <= estado_d;
            pc_tab_q   <= pc_tab_d;
            fsm_q      <= fsm_d;
            causa_q    <= causa_d;
            cnt_q      <= cnt_d;
            cur_q      <= cur_d;
            pid_q      <= pid_d;
            cria_pid_q <= cria_pid_d;
            pc_prox_q  <= pc_prox_d;
            pc_lat_q   <= pc_lat_d;
        end
    end

    assign cria_ready     = livre_found;
    assign cria_pid       = cria_pid_q;
    assign troca_contexto = (fsm_q == FSM_DISPATCH);
    assign pc_proximo     = pc_prox_q;
    assign processo_atual = pid_q;
    assign ocioso         = (fsm_q == FSM_OCIOSO);

endmodule
